// File: rtl/mc_ctrl_unit.sv
// ---------------------------------------------------------------------------
// mc_ctrl_unit -- multicycle MIPS-subset main controller (Moore FSM plus ALU
// decoder). It sequences lw, sw, R-type (add/sub/and/or/slt), addi, beq and j
// over 3 to 5 cycles, and flags unsupported opcodes and functs.
//
// Optional feature: define BNE_EN to add bne (op 000101). bne reuses the
// BRANCH state; the branch condition is inverted for that opcode.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high; returns the FSM to FETCH
//   op, funct     instr[31:26] / instr[5:0] from the instruction register
//   zero          ALU zero flag, current cycle
//   iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a
//                 datapath mux selects and write enables
//   alu_src_b     00 rd2, 01 const 4, 10 signimm, 11 signimm<<2
//   pc_src        00 alu_res, 01 alu_out register, 10 jump target
//   alu_ctrl_sig  010 add, 110 sub, 000 and, 001 or, 111 slt
//   pc_en         PC load enable
//   illegal_op    one-cycle unsupported-instruction flag
//   state         current FSM state (debug)
// ---------------------------------------------------------------------------
module mc_ctrl_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       iord,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [2:0] alu_ctrl_sig,
   output logic       pc_en,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEXEC = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t     state_reg;
   state_t     state_next;
   logic       pc_write;
   logic       branch;
   logic       branch_cond;
   logic       funct_ok;
   logic [2:0] funct_alu;
   logic       abort;
   logic       reg_write_raw;
   logic       mem_write_raw;
   logic       ir_write_raw;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   // R-type function decoder; unsupported functs fall back to add.
   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         default:   funct_ok  = 1'b0;
      endcase
   end

   // The instruction register is stable in BRANCH, so the opcode can pick the
   // branch sense directly.
`ifdef BNE_EN
   assign branch_cond = (op == OP_BNE) ? ~zero : zero;
`else
   assign branch_cond = zero;
`endif

   always_comb begin
      state_next    = FETCH;
      iord          = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write_raw = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_src        = 2'b00;
      alu_ctrl_sig  = ALU_ADD;
      pc_write      = 1'b0;
      branch        = 1'b0;
      illegal_op    = 1'b0;
      case (state_reg)
         FETCH: begin
            alu_src_b    = 2'b01;
            ir_write_raw = 1'b1;
            pc_write     = 1'b1;
            state_next   = DECODE;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_RTYPE:     state_next = EXECUTE;
               OP_BEQ:       state_next = BRANCH;
`ifdef BNE_EN
               OP_BNE:       state_next = BRANCH;
`endif
               OP_ADDI:      state_next = ADDIEXEC;
               OP_J:         state_next = JUMP;
               default: begin
                  state_next = FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            state_next = (op == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            iord       = 1'b1;
            state_next = MEMWB;
         end
         MEMWB: begin
            reg_write_raw = 1'b1;
            mem_to_reg    = 1'b1;
         end
         MEMWR: begin
            iord          = 1'b1;
            mem_write_raw = 1'b1;
         end
         EXECUTE: begin
            alu_src_a    = 1'b1;
            alu_ctrl_sig = funct_alu;
            illegal_op   = ~funct_ok;
            state_next   = funct_ok ? ALUWB : FETCH;
         end
         ALUWB: begin
            reg_dst       = 1'b1;
            reg_write_raw = 1'b1;
         end
         BRANCH: begin
            alu_src_a    = 1'b1;
            alu_ctrl_sig = ALU_SUB;
            pc_src       = 2'b01;
            branch       = 1'b1;
         end
         ADDIEXEC: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            state_next = ADDIWB;
         end
         ADDIWB: begin
            reg_write_raw = 1'b1;
         end
         JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         default: state_next = FETCH;
      endcase
   end

   // A reset arriving mid-instruction suppresses that instruction's remaining
   // writes in the same cycle; FETCH outputs are left untouched by reset.
   assign abort     = reset && (state_reg != FETCH);
   assign reg_write = reg_write_raw & ~abort;
   assign mem_write = mem_write_raw & ~abort;
   assign ir_write  = ir_write_raw & ~abort;
   assign pc_en     = ~abort & (pc_write | (branch & branch_cond));
   assign state     = state_reg;

endmodule

// File: doc/mc_ctrl_unit.md
MC_CTRL_UNIT -- requirements
Module: mc_ctrl_unit

Interface
REQ-001 Parameters: none; all widths SHALL be fixed (32-bit MIPS subset, 3-bit ALU control).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  6  instr[31:26] from the instruction register; stable except in the cycle after ir_write.
REQ-005 funct  in  6  instr[5:0] from the instruction register.
REQ-006 zero  in  1  ALU zero flag for the current cycle.
REQ-007 iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a  out  1 each  datapath mux and enable controls.
REQ-008 alu_src_b  out  2  00=rd2, 01=const 4, 10=signimm, 11=signimm<<2.
REQ-009 pc_src  out  2  00=alu_res, 01=alu_out register, 10=jump target.
REQ-010 alu_ctrl_sig  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt; 011 SHALL never be driven.
REQ-011 pc_en  out  1  PC load enable.
REQ-012 illegal_op  out  1  unsupported-instruction flag.
REQ-013 state  out  4  current FSM state, for debug and verification.

Function
REQ-014 Moore FSM; states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH.
REQ-015 Transitions: FETCH->DECODE; MEMADR->MEMRD for lw (100011), MEMADR->MEMWR for sw; MEMRD->MEMWB; ADDIEXEC->ADDIWB; MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
REQ-016 DECODE by op: 100011 or 101011->MEMADR; 000000->EXECUTE; 000100->BRANCH; 001000->ADDIEXEC; 000010->JUMP; any other op->FETCH.
REQ-017 EXECUTE->ALUWB for funct 100000, 100010, 100100, 100101, 101010; any other funct->FETCH with no register write.
REQ-018 Any output not listed for a state SHALL be 0, with alu_ctrl_sig=010.
REQ-019 FETCH: alu_src_b=01, ir_write=1, pc_write=1, pc_src=00.
REQ-020 DECODE: alu_src_b=11.
REQ-021 MEMADR and ADDIEXEC: alu_src_a=1, alu_src_b=10.
REQ-022 MEMRD: iord=1.
REQ-023 MEMWB: reg_write=1, mem_to_reg=1.
REQ-024 MEMWR: iord=1, mem_write=1.
REQ-025 EXECUTE: alu_src_a=1, alu_src_b=00, alu_ctrl_sig per funct (add 010, sub 110, and 000, or 001, slt 111; unsupported funct 010).
REQ-026 ALUWB: reg_dst=1, reg_write=1.
REQ-027 ADDIWB: reg_write=1.
REQ-028 BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl_sig=110, pc_src=01, branch=1.
REQ-029 JUMP: pc_src=10, pc_write=1.
REQ-030 pc_en SHALL equal pc_write OR (branch AND zero), combinationally within the same cycle.
REQ-031 illegal_op SHALL be high for exactly the one cycle in which an unsupported op is in DECODE, or an unsupported funct is in EXECUTE.
REQ-032 Cycles from FETCH entry back to FETCH entry SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2 (op) or 3 (funct).

Reset
REQ-033 reset high at a clock edge SHALL force state=FETCH from any state, mid-instruction included, with no further write enables issued for the aborted instruction.
REQ-034 While state=FETCH after reset, outputs SHALL be the FETCH values: ir_write=1, pc_en=1, alu_src_b=01, alu_ctrl_sig=010, all other outputs 0.

Configuration
REQ-035 Macro BNE_EN defined: op 000101 in DECODE SHALL go to BRANCH, with pc_en = branch AND NOT zero for that op; beq behaviour SHALL be unchanged.
REQ-036 BNE_EN undefined: op 000101 SHALL be treated as illegal per REQ-016 and REQ-031.

Verification
REQ-037 reset=1 for 2 cycles in state 7 -> state=0, ir_write=1, pc_en=1, reg_write=0 on the following cycle.
REQ-038 op=100011 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-039 op=000000 funct=101010 -> alu_ctrl_sig=111 in state 6, then reg_dst=1 and reg_write=1 in state 7; funct=000011 -> illegal_op=1 in state 6, next state 0, reg_write never 1.
REQ-040 op=000100 with zero=1 -> pc_en=1, pc_src=01 in state 8; with zero=0 -> pc_en=0.
REQ-041 op=000101 with zero=0: BNE_EN defined -> state 8 with pc_en=1; undefined -> illegal_op=1 in state 1, then state 0.
REQ-042 op=000010 -> states 0,1,11,0 with pc_src=10 and pc_en=1 in state 11; op=111111 -> illegal_op=1 in state 1, no write enables asserted.
